niosduino_pwm_array: RTL and testbench
======================================

NIOSDUINO_PWM_ARRAY -- requirements
Module: niosduino_pwm_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of PWM channels (legal 1..32).
REQ-002 SHALL have parameter CNT_W, default 16, width of the period, duty and prescale counters (legal 2..32).
REQ-003 SHALL have port clk_in_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port avs_address  input  6  word address of the Avalon-MM slave.
REQ-006 SHALL have port avs_write  input  1  write strobe.
REQ-007 SHALL have port avs_writedata  input  32  write data.
REQ-008 SHALL have port avs_read  input  1  read strobe.
REQ-009 SHALL have port avs_readdata  output  32  read data, fixed read latency 1.
REQ-010 SHALL have port irq  output  1  level interrupt.
REQ-011 SHALL have port pwm_out  output  NUM_CH  registered PWM outputs.

Function
REQ-012 SHALL implement the register map: 0 CTRL (bit0 EN, bit1 CENTER, bit2 IRQ_EN); 1 PERIOD; 2 PRESCALE; 3 STATUS (bit0 PEND, write-1-to-clear); 4+i DUTY[i] for i < NUM_CH.
REQ-013 SHALL truncate PERIOD, PRESCALE and DUTY writes to CNT_W bits and zero-extend them on readback.
REQ-014 SHALL ignore writes to unmapped addresses and return 0 when they are read.
REQ-015 SHALL drive avs_readdata with the addressed value on the cycle after avs_read; otherwise it holds its previous value.
REQ-016 SHALL keep the written (shadow) PERIOD, PRESCALE and DUTY registers separate from the active copies used by the counters.
REQ-017 SHALL copy all shadow registers into the active copies in the same cycle, and only at a period boundary or on an EN 0->1 transition.
REQ-018 SHALL run a prescaler that counts 0..PRESCALE_a and asserts tick when it equals PRESCALE_a, then returns to 0; PRESCALE_a = 0 gives a tick every cycle.
REQ-019 SHALL, in edge mode (CENTER = 0), advance the counter on tick 0..PERIOD_a, wrapping to 0; the boundary is the tick at which the counter equals PERIOD_a.
REQ-020 SHALL, in center mode (CENTER = 1), count up 0..PERIOD_a and then down to 0, visiting each endpoint once; the boundary is the tick at which the counter equals 0 while counting down.
REQ-021 SHALL compute pwm_out[i] as EN AND (cnt < DUTY_a[i]), registered so that it lags the counter by one cycle.
REQ-022 SHALL keep pwm_out[i] always low when DUTY_a[i] = 0, and always high while enabled when DUTY_a[i] > PERIOD_a.
REQ-023 SHALL, when PERIOD_a = 0, hold the counter at 0 and treat every tick as a boundary.
REQ-024 SHALL, while EN = 0, hold the counter, prescaler and direction at 0/up and drive pwm_out low from the next cycle.
REQ-025 SHALL, on EN 0->1, load the active registers and start counting from 0 with the prescaler at 0.
REQ-026 SHALL apply a CENTER change only at the next boundary or enable.
REQ-027 SHALL set STATUS.PEND on every boundary; a simultaneous boundary and write-1-clear leaves PEND set.
REQ-028 SHALL drive irq = PEND AND IRQ_EN, registered.

Reset
REQ-029 SHALL, while reset_reset_n is low at a clock edge, clear all registers, shadow and active copies, the counter, the prescaler and PEND to 0, set direction to up, and drive pwm_out = 0, irq = 0 and avs_readdata = 0.
REQ-030 SHALL treat a reset asserted mid-period or mid-transaction as absolute: no partial write is kept and a pending read returns 0.

Verification
REQ-031 SHALL cover edge mode: PERIOD = 9, PRESCALE = 0, DUTY[0] = 3, EN = 1 -> pwm_out[0] high 3 of every 10 cycles, PEND set every 10 cycles.
REQ-032 SHALL cover center mode: PERIOD = 4, DUTY[1] = 2, CENTER = 1 -> 8-cycle period, pwm_out[1] pattern 1,1,0,0,0,0,0,1 starting from cnt = 0, up.
REQ-033 SHALL cover shadowing: write DUTY[0] = 7 mid-period with PERIOD = 9 -> the old duty is kept until the wrap, and 7 applies from the next period.
REQ-034 SHALL cover extremes and prescale: DUTY = 0 -> constantly low; DUTY = 10 with PERIOD = 9 -> constantly high; PRESCALE = 2 -> the period stretches to 30 cycles.
REQ-035 SHALL cover the interrupt: IRQ_EN = 1 -> irq rises one cycle after a boundary; a write of 1 to STATUS in the same cycle as the next boundary leaves irq high.
REQ-036 SHALL cover reset: reset_reset_n pulsed low during counting -> all outputs 0, and a readback of all registers returns 0.

Source files
------------

// File: rtl/niosduino_pwm_array.sv
// Avalon-MM controlled PWM array: one shared period counter (edge or center aligned),
// shadowed period/prescale/duty registers and a level interrupt on period boundaries.

module niosduino_pwm_array #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in_clk,
    input  logic              reset_reset_n,
    input  logic [5:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [5:0] ADDR_CTRL     = 6'd0;
    localparam logic [5:0] ADDR_PERIOD   = 6'd1;
    localparam logic [5:0] ADDR_PRESCALE = 6'd2;
    localparam logic [5:0] ADDR_STATUS   = 6'd3;
    localparam int         DUTY_BASE     = 4;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Control register: bit0 EN, bit1 CENTER, bit2 IRQ_EN
    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] periodSh_q, periodSh_d;
    logic [CNT_W-1:0] prescaleSh_q, prescaleSh_d;
    logic [CNT_W-1:0] dutySh_q [NUM_CH];
    logic [CNT_W-1:0] dutySh_d [NUM_CH];

    logic [CNT_W-1:0] periodAct_q, periodAct_d;
    logic [CNT_W-1:0] prescaleAct_q, prescaleAct_d;
    logic [CNT_W-1:0] dutyAct_q [NUM_CH];
    logic [CNT_W-1:0] dutyAct_d [NUM_CH];
    logic             centerAct_q, centerAct_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] psc_q, psc_d;
    logic             dir_q, dir_d;
    logic             pend_q, pend_d;
    logic             irq_q, irq_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        wrCtrl, wrPeriod, wrPrescale, wrStatus;
    logic        enRise, run, tick, boundary, load;
    logic [31:0] readValue;
    logic        unusedWdata;

    assign wrCtrl      = avs_write && (avs_address == ADDR_CTRL);
    assign wrPeriod    = avs_write && (avs_address == ADDR_PERIOD);
    assign wrPrescale  = avs_write && (avs_address == ADDR_PRESCALE);
    assign wrStatus    = avs_write && (avs_address == ADDR_STATUS);
    assign enRise      = wrCtrl && avs_writedata[0] && !ctrl_q[0];
    assign run         = ctrl_q[0];
    assign tick        = run && (psc_q == prescaleAct_q);
    assign unusedWdata = ^avs_writedata;

    always_comb begin
        ctrl_d       = wrCtrl ? avs_writedata[2:0] : ctrl_q;
        periodSh_d   = wrPeriod ? avs_writedata[CNT_W-1:0] : periodSh_q;
        prescaleSh_d = wrPrescale ? avs_writedata[CNT_W-1:0] : prescaleSh_q;
        for (int i = 0; i < NUM_CH; i++) begin
            dutySh_d[i] = dutySh_q[i];
            if (avs_write && (avs_address == 6'(DUTY_BASE + i))) begin
                dutySh_d[i] = avs_writedata[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        readValue = '0;
        case (avs_address)
            ADDR_CTRL:     readValue = {29'd0, ctrl_q};
            ADDR_PERIOD:   readValue = 32'(periodSh_q);
            ADDR_PRESCALE: readValue = 32'(prescaleSh_q);
            ADDR_STATUS:   readValue = {31'd0, pend_q};
            default:       readValue = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == 6'(DUTY_BASE + i)) begin
                readValue = 32'(dutySh_q[i]);
            end
        end
        rdata_d = avs_read ? readValue : rdata_q;
    end

    // Center-mode boundary restarts at 1 so the 0 endpoint is visited once per period
    always_comb begin
        cnt_d    = cnt_q;
        psc_d    = psc_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (!run) begin
            cnt_d = CNT_ZERO;
            psc_d = CNT_ZERO;
            dir_d = DIR_UP;
        end else begin
            psc_d = tick ? CNT_ZERO : (psc_q + CNT_ONE);
            if (tick) begin
                if (periodAct_q == CNT_ZERO) begin
                    boundary = 1'b1;
                    cnt_d    = CNT_ZERO;
                    dir_d    = DIR_UP;
                end else if (!centerAct_q) begin
                    dir_d = DIR_UP;
                    if (cnt_q == periodAct_q) begin
                        boundary = 1'b1;
                        cnt_d    = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == periodAct_q) begin
                        dir_d = DIR_DOWN;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    if (cnt_q == CNT_ZERO) begin
                        boundary = 1'b1;
                        dir_d    = DIR_UP;
                        cnt_d    = (periodSh_q == CNT_ZERO) ? CNT_ZERO : CNT_ONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
        end
    end

    assign load = enRise || boundary;

    always_comb begin
        periodAct_d   = load ? periodSh_q : periodAct_q;
        prescaleAct_d = load ? prescaleSh_q : prescaleAct_q;
        centerAct_d   = centerAct_q;
        if (enRise) begin
            centerAct_d = avs_writedata[1];
        end else if (boundary) begin
            centerAct_d = ctrl_q[1];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            dutyAct_d[i] = load ? dutySh_q[i] : dutyAct_q[i];
            pwm_d[i]     = run && (cnt_q < dutyAct_q[i]);
        end
    end

    // A boundary in the same cycle as a write-1-to-clear keeps PEND set
    always_comb begin
        pend_d = (pend_q && !(wrStatus && avs_writedata[0])) || boundary;
        irq_d  = pend_d && ctrl_q[2];
    end

    always_ff @(posedge clk_in_clk) begin
        if (!reset_reset_n) begin
            ctrl_q        <= '0;
            periodSh_q    <= '0;
            prescaleSh_q  <= '0;
            periodAct_q   <= '0;
            prescaleAct_q <= '0;
            centerAct_q   <= 1'b0;
            cnt_q         <= '0;
            psc_q         <= '0;
            dir_q         <= DIR_UP;
            pend_q        <= 1'b0;
            irq_q         <= 1'b0;
            pwm_q         <= '0;
            rdata_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dutySh_q[i]  <= '0;
                dutyAct_q[i] <= '0;
            end
        end else begin
            ctrl_q        <= ctrl_d;
            periodSh_q    <= periodSh_d;
            prescaleSh_q  <= prescaleSh_d;
            periodAct_q   <= periodAct_d;
            prescaleAct_q <= prescaleAct_d;
            centerAct_q   <= centerAct_d;
            cnt_q         <= cnt_d;
            psc_q         <= psc_d;
            dir_q         <= dir_d;
            pend_q        <= pend_d;
            irq_q         <= irq_d;
            pwm_q         <= pwm_d;
            rdata_q       <= rdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                dutySh_q[i]  <= dutySh_d[i];
                dutyAct_q[i] <= dutyAct_d[i];
            end
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_niosduino_pwm_array.sv
// Directed bench for niosduino_pwm_array: edge/center patterns, shadowing,
// extremes, prescale, interrupt clear and mid-run reset, all against hand-computed vectors.

module tb_niosduino_pwm_array;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              resetN;
    logic [5:0]        avsAddress;
    logic              avsWrite;
    logic [31:0]       avsWritedata;
    logic              avsRead;
    logic [31:0]       avsReaddata;
    logic              irq;
    logic [NUM_CH-1:0] pwmOut;

    int checkCount = 0;
    int failCount  = 0;

    logic [63:0] pwmBits;
    logic [63:0] irqBits;
    logic [31:0] rdData;

    niosduino_pwm_array #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_in_clk   (clk),
        .reset_reset_n(resetN),
        .avs_address  (avsAddress),
        .avs_write    (avsWrite),
        .avs_writedata(avsWritedata),
        .avs_read     (avsRead),
        .avs_readdata (avsReaddata),
        .irq          (irq),
        .pwm_out      (pwmOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One register write; returns #1 after the edge that captured it
    task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data);
        avsAddress   = addr;
        avsWritedata = data;
        avsWrite     = 1'b1;
        @(posedge clk);
        #1;
        avsWrite = 1'b0;
    endtask

    task automatic readReg(input logic [5:0] addr, output logic [31:0] data);
        avsAddress = addr;
        avsRead    = 1'b1;
        @(posedge clk);
        #1;
        avsRead = 1'b0;
        data    = avsReaddata;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sampleCycles(input int n, input int ch, output logic [63:0] pBits, output logic [63:0] iBits);
        logic [NUM_CH-1:0] shifted;
        pBits = '0;
        iBits = '0;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            shifted = pwmOut >> ch;
            pBits   = pBits | (64'(shifted[0]) << j);
            iBits   = iBits | (64'(irq) << j);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN       = 1'b0;
        avsAddress   = '0;
        avsWrite     = 1'b0;
        avsWritedata = '0;
        avsRead      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        $display("[TB] reset released");

        checkOutput("reset_pwm", 64'(pwmOut), 64'h0);
        checkOutput("reset_irq", 64'(irq), 64'h0);
        checkOutput("reset_readdata", 64'(avsReaddata), 64'h0);

        applyStimulus(6'd1, 32'hFFFF_1234);
        readReg(6'd1, rdData);
        checkOutput("period_truncate", 64'(rdData), 64'h1234);
        applyStimulus(6'd12, 32'h0000_DEAD);
        readReg(6'd12, rdData);
        checkOutput("unmapped_12", 64'(rdData), 64'h0);
        applyStimulus(6'd40, 32'h1234_5678);
        readReg(6'd40, rdData);
        checkOutput("unmapped_40", 64'(rdData), 64'h0);
        applyStimulus(6'd11, 32'h000A_BCDE);
        readReg(6'd11, rdData);
        checkOutput("duty7_truncate", 64'(rdData), 64'hBCDE);

        $display("[TB] edge mode, period 9, duty 3");
        applyStimulus(6'd1, 32'd9);
        applyStimulus(6'd2, 32'd0);
        applyStimulus(6'd4, 32'd3);
        applyStimulus(6'd3, 32'd1);
        applyStimulus(6'd0, 32'd5);
        sampleCycles(20, 0, pwmBits, irqBits);
        checkOutput("edge_pwm0", pwmBits, 64'h1C07);
        checkOutput("edge_irq", irqBits, 64'hFFE00);

        $display("[TB] duty shadowing");
        applyStimulus(6'd4, 32'd7);
        sampleCycles(20, 0, pwmBits, irqBits);
        checkOutput("shadow_pwm0", pwmBits, 64'h8FE03);
        readReg(6'd4, rdData);
        checkOutput("shadow_readback", 64'(rdData), 64'd7);

        $display("[TB] duty extremes");
        applyStimulus(6'd0, 32'd0);
        applyStimulus(6'd4, 32'd0);
        applyStimulus(6'd5, 32'd10);
        applyStimulus(6'd0, 32'd1);
        sampleCycles(20, 0, pwmBits, irqBits);
        checkOutput("duty0_low", pwmBits, 64'h0);
        sampleCycles(20, 1, pwmBits, irqBits);
        checkOutput("duty10_high", pwmBits, 64'hFFFFF);
        applyStimulus(6'd0, 32'd0);
        idleCycles(1);
        checkOutput("disable_low", 64'(pwmOut), 64'h0);

        $display("[TB] prescale 2");
        applyStimulus(6'd2, 32'd2);
        applyStimulus(6'd4, 32'd3);
        applyStimulus(6'd0, 32'd1);
        sampleCycles(40, 0, pwmBits, irqBits);
        checkOutput("prescale_pwm0", pwmBits, 64'h0000_007F_C000_01FF);
        applyStimulus(6'd0, 32'd0);
        applyStimulus(6'd2, 32'd0);

        $display("[TB] center mode, period 4, duty 2");
        applyStimulus(6'd1, 32'd4);
        applyStimulus(6'd5, 32'd2);
        applyStimulus(6'd3, 32'd1);
        applyStimulus(6'd0, 32'd7);
        sampleCycles(16, 1, pwmBits, irqBits);
        checkOutput("center_pwm1", pwmBits, 64'h8383);
        checkOutput("center_irq", irqBits, 64'hFF00);

        $display("[TB] interrupt and write-1-to-clear");
        applyStimulus(6'd0, 32'd0);
        applyStimulus(6'd1, 32'd9);
        applyStimulus(6'd4, 32'd3);
        applyStimulus(6'd3, 32'd1);
        applyStimulus(6'd0, 32'd5);
        sampleCycles(12, 0, pwmBits, irqBits);
        checkOutput("irq_rise", irqBits, 64'hE00);
        idleCycles(7);
        applyStimulus(6'd3, 32'd1);
        checkOutput("irq_clear_at_boundary", 64'(irq), 64'h1);
        applyStimulus(6'd3, 32'd1);
        checkOutput("irq_cleared", 64'(irq), 64'h0);
        readReg(6'd3, rdData);
        checkOutput("status_cleared", 64'(rdData), 64'h0);
        idleCycles(8);
        checkOutput("irq_rearm", 64'(irq), 64'h1);
        readReg(6'd0, rdData);
        checkOutput("ctrl_readback", 64'(rdData), 64'h5);

        $display("[TB] reset during counting with pending access");
        resetN       = 1'b0;
        avsAddress   = 6'd1;
        avsWritedata = 32'h55;
        avsWrite     = 1'b1;
        avsRead      = 1'b1;
        @(posedge clk);
        #1;
        resetN   = 1'b1;
        avsWrite = 1'b0;
        avsRead  = 1'b0;
        checkOutput("midreset_readdata", 64'(avsReaddata), 64'h0);
        checkOutput("midreset_irq", 64'(irq), 64'h0);
        checkOutput("midreset_pwm", 64'(pwmOut), 64'h0);
        for (int a = 0; a < 12; a++) begin
            readReg(6'(a), rdData);
            checkOutput($sformatf("midreset_reg%0d", a), 64'(rdData), 64'h0);
        end
        checkOutput("after_reset_pwm", 64'(pwmOut), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
